regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port arbiter and scoreboard for the RV32IM register file. It shares the register file's single write port between the single-cycle ALU/load writeback path and the multi-cycle mul/div unit. It tracks which destination registers have mul/div results outstanding and flags read-after-write hazards to the decoder. It sits between the execute stage and the register file write port, and drives `we`, `rd_addr` and `rd` from registered outputs.

## Interface
- `DATA_WIDTH`, from `definitions.vh` (32): width of the write data.
- `NUM_REGISTER`, from `definitions.vh` (32): register count. `AW = $clog2(NUM_REGISTER)`.
- `STARVE_LIMIT`, default 4: consecutive lost arbitration cycles before mul/div is promoted. Legal range 1..15.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_alu_valid`  in  1  ALU writeback request.
- `i_alu_rd_addr`  in  AW  ALU destination register.
- `i_alu_rd`  in  DATA_WIDTH  ALU result.
- `o_alu_ready`  out  1  ALU request accepted this cycle.
- `i_md_valid`  in  1  mul/div writeback request.
- `i_md_rd_addr`  in  AW  mul/div destination register.
- `i_md_rd`  in  DATA_WIDTH  mul/div result.
- `o_md_ready`  out  1  mul/div request accepted this cycle.
- `i_md_issue`  in  1  a mul/div operation is dispatched this cycle.
- `i_md_issue_rd`  in  AW  destination of the dispatched operation.
- `i_rs1_addr`, `i_rs2_addr`, `i_dec_rd_addr`  in  AW each  operands and destination of the instruction in decode.
- `o_hazard`  out  1  the decode instruction touches a busy register.
- `o_we`  out  1  register file write enable.
- `o_rd_addr`  out  AW  register file write address.
- `o_rd`  out  DATA_WIDTH  register file write data.

## Operation
- **Handshake:** a request transfers when `valid && ready`. A requester holds `valid`, address and data stable until it is accepted.
- **Arbitration FSM**, two states:
  - `ALU_PRIO` (reset state): the ALU wins any conflict. Each cycle `i_md_valid` is high and mul/div loses, `starve_cnt` increments.
  - When `starve_cnt` reaches `STARVE_LIMIT`, go to `MD_PRIO`. In `MD_PRIO`, mul/div wins a conflict.
  - Any mul/div acceptance clears `starve_cnt` and returns the FSM to `ALU_PRIO`.
- **Single requester:** a lone requester is always granted in either state.
- **Ready signals:** `o_alu_ready` and `o_md_ready` are combinational from the valids and state. They are never both 1 unless one request targets x0.
- **x0 requests:** a request with address 0 is accepted immediately (ready = 1). It produces no `o_we` and does not consume the port. It cannot block or be blocked by the other requester.
- **Scoreboard:** `busy[NUM_REGISTER-1:0]`.
  - `i_md_issue` sets `busy[i_md_issue_rd]`. An issue to x0 is ignored.
  - An accepted mul/div write clears `busy[i_md_rd_addr]`.
  - If a set and a clear hit the same register in one cycle, the set wins.
- **Hazard:** `o_hazard = busy[i_rs1_addr] | busy[i_rs2_addr] | busy[i_dec_rd_addr]`. This is combinational. `busy[0]` is always 0.
- **ALU write to a busy register:** the write proceeds. `busy` is unchanged; the decoder prevents this case through `o_hazard`.

## Timing
- **Write latency:** a request accepted in cycle N appears on `o_we`/`o_rd_addr`/`o_rd` in cycle N+1. The register file commits it at the edge ending N+1.
- **Ready path:** zero-cycle ready, with no ready-to-valid combinational loop.
- **Reset values:** `o_we`=0, `o_rd_addr`=0, `o_rd`=0, `busy`=0, state `ALU_PRIO`, `starve_cnt`=0. While `i_rst` is high, `o_alu_ready`, `o_md_ready` and `o_hazard` are all 0.
- **Reset mid-operation:** any pending output write is discarded and all busy bits clear. Producers restart their handshakes after reset deasserts.
- **Back-to-back:** one write per cycle sustained. Continuous ALU traffic still lets mul/div through within `STARVE_LIMIT`+1 cycles.

## Configuration
- `WBARB_STARVE_EN` defined: the starvation counter and `MD_PRIO` state exist as described above.
- Not defined: strict ALU priority. The FSM and counter are removed, and mul/div is granted only when `i_alu_valid` is low or targets x0. `STARVE_LIMIT` is then unused.

## Structure
- **Shared package additions** (`definitions.vh`): the state encoding constants (`WBARB_ALU_PRIO`=0, `WBARB_MD_PRIO`=1) and the `STARVE_LIMIT` default. `DATA_WIDTH` and `NUM_REGISTER` are already there.
- **Sub-module:** one, `wb_scoreboard`, holding the busy vector with its set/clear/lookup logic. The arbiter, FSM and output registers stay in the top module.

## Test plan
- Reset, then an ALU write of 0xDEADBEEF to x5 → next cycle `o_we`=1, `o_rd_addr`=5, `o_rd`=0xDEADBEEF. The following cycle `o_we`=0.
- Simultaneous ALU (x3) and mul/div (x4) requests with an idle FSM → ALU granted first, x3 written in cycle N+1. Mul/div is granted in cycle N+1 and x4 is written in cycle N+2.
- Continuous ALU valid and continuous mul/div valid with `STARVE_LIMIT`=4 → mul/div granted on the 5th cycle. With the macro undefined, mul/div is never granted.
- `i_md_issue` to x7, then decode with rs1=7 → `o_hazard`=1. The mul/div write to x7 is accepted → `o_hazard`=0 the next cycle. An issue to x0 never raises `o_hazard`.
- Same-cycle mul/div write to x9 and new issue to x9 → `busy[9]` stays 1.
- Assert `i_rst` asynchronously mid-cycle with a write pending and `busy[12]`=1 → `o_we`=0 and `o_hazard`=0 immediately. No write to the register file occurs.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter: datapath sizes,
// arbitration state encoding and the default starvation limit.
package regfile_wb_arbiter_pkg;

    localparam int RF_DATA_WIDTH   = 32;
    localparam int RF_NUM_REGISTER = 32;

    localparam int WBARB_STARVE_LIMIT = 4;

    localparam logic WBARB_ALU_PRIO = 1'b0;
    localparam logic WBARB_MD_PRIO  = 1'b1;

    typedef enum logic {
        ALU_PRIO = WBARB_ALU_PRIO,
        MD_PRIO  = WBARB_MD_PRIO
    } arb_state_t;

    // True once mul/div has lost enough consecutive conflicts to be promoted.
    function automatic logic starve_reached(input logic [3:0] cnt_next, input int limit);
        return cnt_next >= 4'(limit);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Busy-register scoreboard for outstanding mul/div results; flags decode
// hazards on any operand or destination that is still waiting for its result.
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int NUM_REGISTER = RF_NUM_REGISTER,
    localparam int AW           = $clog2(NUM_REGISTER)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_set,
    input  logic [AW-1:0]           i_set_addr,
    input  logic                    i_clr,
    input  logic [AW-1:0]           i_clr_addr,
    input  logic [AW-1:0]           i_rs1_addr,
    input  logic [AW-1:0]           i_rs2_addr,
    input  logic [AW-1:0]           i_dec_rd_addr,
    output logic                    o_hazard
);

    logic [NUM_REGISTER-1:0] busy;
    logic [NUM_REGISTER-1:0] busy_next;

    // Clear is applied first so a same-cycle issue to the same register wins.
    always_comb begin
        busy_next = busy;
        if (i_clr) begin
            busy_next[i_clr_addr] = 1'b0;
        end
        if (i_set && (i_set_addr != '0)) begin
            busy_next[i_set_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign o_hazard = busy[i_rs1_addr] | busy[i_rs2_addr] | busy[i_dec_rd_addr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU/load path and mul/div.
// Define WBARB_STARVE_EN to enable starvation promotion of mul/div; otherwise ALU has strict priority.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int DATA_WIDTH   = RF_DATA_WIDTH,
    parameter  int NUM_REGISTER = RF_NUM_REGISTER,
    parameter  int STARVE_LIMIT = WBARB_STARVE_LIMIT,
    localparam int AW           = $clog2(NUM_REGISTER)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_alu_valid,
    input  logic [AW-1:0]         i_alu_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_alu_rd,
    output logic                  o_alu_ready,
    input  logic                  i_md_valid,
    input  logic [AW-1:0]         i_md_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_md_rd,
    output logic                  o_md_ready,
    input  logic                  i_md_issue,
    input  logic [AW-1:0]         i_md_issue_rd,
    input  logic [AW-1:0]         i_rs1_addr,
    input  logic [AW-1:0]         i_rs2_addr,
    input  logic [AW-1:0]         i_dec_rd_addr,
    output logic                  o_hazard,
    output logic                  o_we,
    output logic [AW-1:0]         o_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd,
    output arb_state_t            o_arb_state
);

    // Handshake: a request transfers in any cycle where valid && ready; the
    // requester holds valid/address/data stable until that cycle. Ready depends
    // only on the valids, addresses and arbitration state, never on itself.

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be within 1..15");
    end

    logic alu_real;
    logic md_real;
    logic md_prio;
    logic alu_ready_c;
    logic md_ready_c;
    logic alu_write;
    logic md_write;

    // x0 requests never touch the port, so only real writes can conflict.
    assign alu_real = i_alu_valid && (i_alu_rd_addr != '0);
    assign md_real  = i_md_valid  && (i_md_rd_addr  != '0);

    assign alu_ready_c = !i_rst && i_alu_valid && !(alu_real && md_real &&  md_prio);
    assign md_ready_c  = !i_rst && i_md_valid  && !(alu_real && md_real && !md_prio);

    assign o_alu_ready = alu_ready_c;
    assign o_md_ready  = md_ready_c;

    assign alu_write = alu_ready_c && alu_real;
    assign md_write  = md_ready_c  && md_real;

`ifdef WBARB_STARVE_EN
    arb_state_t state;
    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_inc;

    assign starve_cnt_inc = starve_cnt + 4'd1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ALU_PRIO;
            starve_cnt <= '0;
        end else if (md_ready_c) begin
            state      <= ALU_PRIO;
            starve_cnt <= '0;
        end else if ((state == ALU_PRIO) && i_md_valid) begin
            // mul/div asked and lost this cycle
            starve_cnt <= starve_cnt_inc;
            if (starve_reached(starve_cnt_inc, STARVE_LIMIT)) begin
                state <= MD_PRIO;
            end
        end
    end

    assign md_prio     = (state == MD_PRIO);
    assign o_arb_state = state;
`else
    assign md_prio     = 1'b0;
    assign o_arb_state = ALU_PRIO;
`endif

    // At most one of alu_write / md_write is set in any cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_we      <= 1'b0;
            o_rd_addr <= '0;
            o_rd      <= '0;
        end else begin
            o_we <= alu_write || md_write;
            if (alu_write) begin
                o_rd_addr <= i_alu_rd_addr;
                o_rd      <= i_alu_rd;
            end else if (md_write) begin
                o_rd_addr <= i_md_rd_addr;
                o_rd      <= i_md_rd;
            end
        end
    end

    wb_scoreboard #(
        .NUM_REGISTER (NUM_REGISTER)
    ) u_scoreboard (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_set         (i_md_issue),
        .i_set_addr    (i_md_issue_rd),
        .i_clr         (md_ready_c),
        .i_clr_addr    (i_md_rd_addr),
        .i_rs1_addr    (i_rs1_addr),
        .i_rs2_addr    (i_rs2_addr),
        .i_dec_rd_addr (i_dec_rd_addr),
        .o_hazard      (o_hazard)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// traffic compared every cycle against a behavioural write-port model.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        issue;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1, rs2, drd;
    logic        hazard;
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    arb_state_t  arb_state;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_alu_valid   (alu_valid),
        .i_alu_rd_addr (alu_addr),
        .i_alu_rd      (alu_data),
        .o_alu_ready   (alu_ready),
        .i_md_valid    (md_valid),
        .i_md_rd_addr  (md_addr),
        .i_md_rd       (md_data),
        .o_md_ready    (md_ready),
        .i_md_issue    (issue),
        .i_md_issue_rd (issue_rd),
        .i_rs1_addr    (rs1),
        .i_rs2_addr    (rs2),
        .i_dec_rd_addr (drd),
        .o_hazard      (hazard),
        .o_we          (we),
        .o_rd_addr     (rd_addr),
        .o_rd          (rd_data),
        .o_arb_state   (arb_state)
    );

    always #5 clk = ~clk;

    // behavioural model state
    logic [36:0] exp_q[$];
    bit          busy_m[32];
    int          losses;
    int          n_vec = 0;
    int          n_err = 0;
    logic        seen_alu, seen_md, seen_hz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        losses = 0;
    endtask

    // One clock cycle: check DUT against the model at the falling edge, advance
    // the model, then return 1 time unit after the next rising edge.
    task automatic step();
        logic        ea, em, eh, ar, mr, mp;
        logic [36:0] w;
        @(negedge clk);
        if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            chk("we", 32'(we), 32'd1);
            chk("rd_addr", 32'(rd_addr), 32'(w[36:32]));
            chk("rd", rd_data, w[31:0]);
        end else begin
            chk("we_idle", 32'(we), 32'd0);
        end
        seen_alu = alu_ready;
        seen_md  = md_ready;
        seen_hz  = hazard;
        ar = alu_valid && (alu_addr != 5'd0);
        mr = md_valid && (md_addr != 5'd0);
        mp = 1'b0;
`ifdef WBARB_STARVE_EN
        mp = (losses >= LIMIT);
`endif
        if (rst) begin
            ea = 1'b0; em = 1'b0; eh = 1'b0;
        end else begin
            ea = alu_valid && !(ar && mr && mp);
            em = md_valid && !(ar && mr && !mp);
            eh = busy_m[rs1] | busy_m[rs2] | busy_m[drd];
        end
        chk("alu_ready", 32'(alu_ready), 32'(ea));
        chk("md_ready", 32'(md_ready), 32'(em));
        chk("hazard", 32'(hazard), 32'(eh));
        if (rst) begin
            model_reset();
        end else begin
            if (ea && ar)      exp_q.push_back({alu_addr, alu_data});
            else if (em && mr) exp_q.push_back({md_addr, md_data});
            if (em) begin
                busy_m[md_addr] = 1'b0;
                losses = 0;
            end else if (md_valid) begin
                losses++;
            end
            if (issue && issue_rd != 5'd0) busy_m[issue_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int grant;
        rst = 1'b1;
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h1111_1111;
        md_valid = 1'b1;  md_addr = 5'd4;  md_data = 32'h2222_2222;
        issue = 1'b0; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; drd = 5'd0;
        model_reset();

        // reset state
        step();
        step();
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_md_ready", 32'(md_ready), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_rd", rd_data, 32'd0);
        chk("rst_hazard", 32'(hazard), 32'd0);
        rst = 1'b0;
        alu_valid = 1'b0; md_valid = 1'b0;
        step();

        // single ALU write
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEAD_BEEF;
        step();
        alu_valid = 1'b0;
        chk("t1_we", 32'(we), 32'd1);
        chk("t1_rd_addr", 32'(rd_addr), 32'd5);
        chk("t1_rd", rd_data, 32'hDEAD_BEEF);
        step();
        chk("t1_we_after", 32'(we), 32'd0);

        // simultaneous ALU x3 / mul-div x4
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h0000_0033;
        md_valid = 1'b1;  md_addr = 5'd4;  md_data = 32'h0000_0044;
        step();
        chk("t2_alu_first", 32'({seen_alu, seen_md}), 32'b10);
        alu_valid = 1'b0;
        chk("t2_x3_written", 32'({we, rd_addr}), 32'({1'b1, 5'd3}));
        step();
        chk("t2_md_second", 32'(seen_md), 32'd1);
        md_valid = 1'b0;
        chk("t2_x4_written", 32'({we, rd_addr}), 32'({1'b1, 5'd4}));
        step();

        // continuous contention: promotion after LIMIT losses
        grant = 0;
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = $urandom;
        md_valid = 1'b1;  md_addr = 5'd2;  md_data = 32'h0000_0202;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (seen_alu) alu_data = $urandom;
            if (seen_md) begin
                grant = i;
                break;
            end
        end
`ifdef WBARB_STARVE_EN
        chk("starve_grant_cycle", grant, 32'd5);
`else
        chk("starve_never_grant", grant, 32'd0);
`endif
        alu_valid = 1'b0;
        for (int i = 0; i < 4 && grant == 0; i++) begin
            step();
            if (seen_md) grant = 99;
        end
        md_valid = 1'b0;
        step();

        // scoreboard hazard on x7
        issue = 1'b1; issue_rd = 5'd7;
        step();
        issue = 1'b0; rs1 = 5'd7;
        step();
        chk("t4_hazard_set", 32'(seen_hz), 32'd1);
        md_valid = 1'b1; md_addr = 5'd7; md_data = 32'h0000_0777;
        step();
        chk("t4_md_accept", 32'(seen_md), 32'd1);
        md_valid = 1'b0;
        step();
        chk("t4_hazard_clear", 32'(seen_hz), 32'd0);
        issue = 1'b1; issue_rd = 5'd0; rs1 = 5'd0;
        step();
        issue = 1'b0;
        step();
        chk("t4_x0_issue", 32'(seen_hz), 32'd0);

        // same-cycle clear and set of x9
        issue = 1'b1; issue_rd = 5'd9;
        step();
        md_valid = 1'b1; md_addr = 5'd9; md_data = 32'h0000_0999;
        step();
        issue = 1'b0; md_valid = 1'b0; drd = 5'd9;
        step();
        chk("t5_set_wins", 32'(seen_hz), 32'd1);
        md_valid = 1'b1;
        step();
        md_valid = 1'b0; drd = 5'd0;
        step();

        // random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            if (!alu_valid && $urandom_range(0, 2) == 0) begin
                alu_valid = 1'b1;
                alu_addr = 5'($urandom_range(0, 15));
                alu_data = $urandom;
            end
            if (!md_valid && $urandom_range(0, 3) == 0) begin
                md_valid = 1'b1;
                md_addr = 5'($urandom_range(0, 15));
                md_data = $urandom;
            end
            issue = ($urandom_range(0, 3) == 0);
            issue_rd = 5'($urandom_range(0, 15));
            rs1 = 5'($urandom_range(0, 15));
            rs2 = 5'($urandom_range(0, 15));
            drd = 5'($urandom_range(0, 15));
            step();
            if (alu_valid && seen_alu) alu_valid = 1'b0;
            if (md_valid && seen_md) md_valid = 1'b0;
        end
        alu_valid = 1'b0; md_valid = 1'b0; issue = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0; drd = 5'd0;
        step();

        // asynchronous reset with a write pending and x12 busy
        issue = 1'b1; issue_rd = 5'd12;
        step();
        issue = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hA5A5_A5A5;
        step();
        chk("t6_pending_we", 32'(we), 32'd1);
        alu_addr = 5'd6; rs1 = 5'd12;
        #1;
        chk("t6_hazard_before", 32'(hazard), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        chk("t6_we_cleared", 32'(we), 32'd0);
        chk("t6_hazard_cleared", 32'(hazard), 32'd0);
        chk("t6_alu_ready_rst", 32'(alu_ready), 32'd0);
        chk("t6_rd_addr_cleared", 32'(rd_addr), 32'd0);
        step();
        rst = 1'b0;
        alu_valid = 1'b0;
        step();
        step();
        chk("t6_no_write", 32'(we), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
